apb_slave_mem: RTL and testbench

APB completer that terminates transfers issued by the team's APB master bridge on the same PCLK domain. It decodes one PSEL line, holds a DEPTH-entry × 8-bit register memory, inserts a programmable number of wait states via PREADY, and flags out-of-range addresses with PSLVERR. Two instances sit behind PSEL1 and PSEL2 of the bridge.

---
 rtl/apb_slave_mem.sv | 140 ++++++++++++++
 tb/tb_apb_slave_mem.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
//
// APB completer holding a DEPTH-entry x 8-bit register memory. Each transfer
// is a setup cycle followed by WAIT_CYCLES wait states and one completing
// access cycle. Addresses at or beyond DEPTH complete with PSLVERR=1, read as
// zero and never modify the memory.
//
// Parameters:
//   DEPTH        number of memory entries, 1..256 (valid addresses 0..DEPTH-1)
//   WAIT_CYCLES  wait states inserted per transfer, 0..15
//
// Ports:
//   PCLK     in   clock, all logic on the rising edge
//   PRESET   in   synchronous active-high reset
//   PSEL     in   select from the master
//   PENABLE  in   access-phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   [7:0] byte address (sampled in setup only)
//   PWDATA   in   [7:0] write data (sampled in setup only)
//   PRDATA   out  [7:0] read data, non-zero only on a completing read
//   PREADY   out  high for exactly the completing access cycle
//   PSLVERR  out  out-of-range error, only while PREADY is high
// -----------------------------------------------------------------------------
module apb_slave_mem #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR
);

    // The storage array is rounded up to a power of two so that it can be
    // indexed directly by the low address bits; entries at or above DEPTH
    // are never reachable because such addresses are flagged as errors.
    localparam int         ADDR_BITS   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         MEM_SIZE    = 1 << ADDR_BITS;
    localparam logic [8:0] DEPTH_LIMIT = 9'(DEPTH);
    localparam logic [3:0] WAIT_INIT   = 4'(WAIT_CYCLES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [7:0]           addr_q;
    logic                 write_q;
    logic [7:0]           wdata_q;
    logic [7:0]           mem [MEM_SIZE];
    logic [ADDR_BITS-1:0] mem_index;
    logic                 err;
    logic                 complete;

    // Only the address captured during setup is ever used; the error check
    // compares the full 8-bit address so high addresses cannot alias onto
    // valid entries through the truncated index.
    assign mem_index = addr_q[ADDR_BITS-1:0];
    assign err       = ({1'b0, addr_q} >= DEPTH_LIMIT);

    // A transfer completes in the access cycle where the wait counter has run
    // out and the master is still holding PSEL and PENABLE. PREADY is derived
    // combinationally so it rises in the same cycle the counter reaches zero.
    assign complete = (state == ACCESS) && PSEL && PENABLE && (cnt == 4'd0);

    // Response outputs are all qualified by the completing cycle so that idle,
    // setup, wait and aborted cycles present zeros on the bus.
    always_comb begin
        PREADY  = complete;
        PSLVERR = complete && err;
        PRDATA  = 8'h00;
        if (complete && !write_q && !err) begin
            PRDATA = mem[mem_index];
        end
    end

    // Transfer sequencer. IDLE waits for a setup phase (PSEL high, PENABLE
    // low), captures the request and loads the wait counter. ACCESS counts
    // down while the master keeps the access phase asserted and returns to
    // IDLE on completion; if the master drops PSEL or PENABLE mid-access the
    // transfer is abandoned and we fall back to IDLE without any side effect.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 8'h00;
            write_q <= 1'b0;
            wdata_q <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        cnt     <= WAIT_INIT;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (PSEL && PENABLE) begin
                        if (cnt == 4'd0) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory array. Reset clears every entry; otherwise the only write port
    // fires on the completing edge of an in-range write, using the data that
    // was captured in the setup cycle.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (complete && write_q && !err) begin
            mem[mem_index] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_mem
//
// Drives three apb_slave_mem instances with different DEPTH / WAIT_CYCLES
// settings: a directed table of transfers, a few hand-written multi-cycle
// sequences (stray enable, master abort, reset mid-transfer) and a random
// phase checked against a simple array model of each memory.
// -----------------------------------------------------------------------------
module tb_apb_slave_mem;

    localparam int N  = 3;
    localparam int D0 = 64;
    localparam int W0 = 1;
    localparam int D1 = 256;
    localparam int W1 = 0;
    localparam int D2 = 100;
    localparam int W2 = 15;

    logic                clk = 1'b0;
    logic                preset;
    logic [N-1:0]        psel;
    logic [N-1:0]        penable;
    logic [N-1:0]        pwrite;
    logic [N-1:0][7:0]   paddr;
    logic [N-1:0][7:0]   pwdata;
    logic [N-1:0][7:0]   prdata;
    logic [N-1:0]        pready;
    logic [N-1:0]        pslverr;

    logic [7:0]          model_mem [N][256];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         inst;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rdata;
        bit         exp_err;
    } vec_t;

    vec_t vecs [$];

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    apb_slave_mem #(.DEPTH(D0), .WAIT_CYCLES(W0)) dut0 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_slave_mem #(.DEPTH(D1), .WAIT_CYCLES(W1)) dut1 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    apb_slave_mem #(.DEPTH(D2), .WAIT_CYCLES(W2)) dut2 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable[2]),
        .PWRITE(pwrite[2]), .PADDR(paddr[2]), .PWDATA(pwdata[2]),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2])
    );

    function automatic int depthOf(input int inst);
        case (inst)
            0:       return D0;
            1:       return D1;
            default: return D2;
        endcase
    endfunction

    function automatic int waitOf(input int inst);
        case (inst)
            0:       return W0;
            1:       return W1;
            default: return W2;
        endcase
    endfunction

    function automatic void addVec(input int inst, input bit wr, input logic [7:0] addr,
                                   input logic [7:0] data, input logic [7:0] exp_rdata,
                                   input bit exp_err);
        vec_t v;
        v.inst      = inst;
        v.wr        = wr;
        v.addr      = addr;
        v.data      = data;
        v.exp_rdata = exp_rdata;
        v.exp_err   = exp_err;
        vecs.push_back(v);
    endfunction

    function automatic void clearModel();
        for (int i = 0; i < N; i++) begin
            for (int a = 0; a < 256; a++) begin
                model_mem[i][a] = 8'h00;
            end
        end
    endfunction

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // All three response outputs must be zero outside a completing cycle.
    task automatic checkIdle(input int inst, input string tag);
        checkOutput($sformatf("inst%0d %s pready", inst, tag), {7'b0, pready[inst]}, 8'h00);
        checkOutput($sformatf("inst%0d %s pslverr", inst, tag), {7'b0, pslverr[inst]}, 8'h00);
        checkOutput($sformatf("inst%0d %s prdata", inst, tag), prdata[inst], 8'h00);
    endtask

    task automatic idleCycle(input int inst);
        @(negedge clk);
        checkIdle(inst, "idle");
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        preset  = 1'b1;
        psel    = '0;
        penable = '0;
        repeat (2) @(posedge clk);
        #1;
        preset = 1'b0;
        clearModel();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            checkIdle(i, "after reset");
        end
        @(posedge clk);
        #1;
    endtask

    // One APB transfer, entered and left 1 time unit after a rising edge.
    // The PREADY level is checked in every access cycle, so the transfer
    // length and the single-cycle pulse are both verified. drop >= 0 makes
    // the master abandon the transfer in that access cycle. PADDR/PWDATA
    // are scrambled during access since the completer must not resample them.
    task automatic applyStimulus(input int inst, input bit wr, input logic [7:0] addr,
                                 input logic [7:0] data, input int drop,
                                 input logic [7:0] exp_rdata, input bit exp_err);
        int w;
        w = waitOf(inst);
        psel[inst]    = 1'b1;
        penable[inst] = 1'b0;
        pwrite[inst]  = wr;
        paddr[inst]   = addr;
        pwdata[inst]  = data;
        @(negedge clk);
        checkOutput($sformatf("inst%0d setup pready", inst), {7'b0, pready[inst]}, 8'h00);
        @(posedge clk);
        #1;
        penable[inst] = 1'b1;
        paddr[inst]   = 8'($urandom);
        pwdata[inst]  = 8'($urandom);
        for (int k = 0; k <= w; k++) begin
            if (k == drop) begin
                psel[inst]    = 1'b0;
                penable[inst] = 1'b0;
                @(negedge clk);
                checkOutput($sformatf("inst%0d abort pready", inst), {7'b0, pready[inst]}, 8'h00);
                @(posedge clk);
                #1;
                return;
            end
            @(negedge clk);
            checkOutput($sformatf("inst%0d access%0d pready", inst, k),
                        {7'b0, pready[inst]}, (k == w) ? 8'h01 : 8'h00);
            if (k == w) begin
                checkOutput($sformatf("inst%0d addr %h pslverr", inst, addr),
                            {7'b0, pslverr[inst]}, {7'b0, exp_err});
                if (!wr) begin
                    checkOutput($sformatf("inst%0d addr %h prdata", inst, addr),
                                prdata[inst], exp_rdata);
                end
            end
            @(posedge clk);
            #1;
        end
        if (wr && (int'(addr) < depthOf(inst))) begin
            model_mem[inst][addr] = data;
        end
        psel[inst]    = 1'b0;
        penable[inst] = 1'b0;
    endtask

    // Safety net in case the bench itself wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         inst;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        int         drop;
        int         r;
        bit         e;

        preset  = 1'b1;
        psel    = '0;
        penable = '0;
        pwrite  = '0;
        paddr   = '0;
        pwdata  = '0;
        clearModel();

        doReset();

        // Directed table, applied back-to-back with no idle cycles.
        addVec(0, 1'b0, 8'h05, 8'h00, 8'h00, 1'b0);
        addVec(0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
        addVec(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
        addVec(0, 1'b1, 8'h40, 8'h3C, 8'h00, 1'b1);
        addVec(0, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1);
        addVec(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        addVec(0, 1'b1, 8'h3F, 8'h5C, 8'h00, 1'b0);
        addVec(0, 1'b0, 8'h3F, 8'h00, 8'h5C, 1'b0);
        addVec(1, 1'b1, 8'hFF, 8'h11, 8'h00, 1'b0);
        addVec(1, 1'b0, 8'hFF, 8'h00, 8'h11, 1'b0);
        addVec(1, 1'b0, 8'h40, 8'h00, 8'h00, 1'b0);
        addVec(2, 1'b1, 8'h63, 8'h5A, 8'h00, 1'b0);
        addVec(2, 1'b0, 8'h63, 8'h00, 8'h5A, 1'b0);
        addVec(2, 1'b1, 8'h64, 8'hE7, 8'h00, 1'b1);
        addVec(2, 1'b0, 8'h64, 8'h00, 8'h00, 1'b1);
        addVec(2, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].inst, vecs[i].wr, vecs[i].addr, vecs[i].data, -1,
                          vecs[i].exp_rdata, vecs[i].exp_err);
        end
        idleCycle(2);

        // Access phase without a preceding setup must be ignored.
        psel[0]    = 1'b1;
        penable[0] = 1'b1;
        pwrite[0]  = 1'b0;
        paddr[0]   = 8'h10;
        repeat (4) begin
            @(negedge clk);
            checkOutput("inst0 stray enable pready", {7'b0, pready[0]}, 8'h00);
            @(posedge clk);
            #1;
        end
        psel[0]    = 1'b0;
        penable[0] = 1'b0;
        idleCycle(0);
        applyStimulus(0, 1'b0, 8'h10, 8'h00, -1, 8'hA5, 1'b0);

        // Master drops PSEL during wait states: no write, returns to idle.
        applyStimulus(0, 1'b1, 8'h02, 8'hFF, 0, 8'h00, 1'b0);
        idleCycle(0);
        applyStimulus(0, 1'b0, 8'h02, 8'h00, -1, 8'h00, 1'b0);
        applyStimulus(2, 1'b1, 8'h07, 8'h33, 7, 8'h00, 1'b0);
        idleCycle(2);
        applyStimulus(2, 1'b0, 8'h07, 8'h00, -1, 8'h00, 1'b0);

        // Reset during the access phase of a write: outputs clear next cycle,
        // the write is lost and earlier contents are wiped.
        applyStimulus(0, 1'b1, 8'h03, 8'h11, -1, 8'h00, 1'b0);
        psel[0]    = 1'b1;
        penable[0] = 1'b0;
        pwrite[0]  = 1'b1;
        paddr[0]   = 8'h03;
        pwdata[0]  = 8'h77;
        @(posedge clk);
        #1;
        penable[0] = 1'b1;
        preset     = 1'b1;
        @(posedge clk);
        #1;
        preset     = 1'b0;
        psel[0]    = 1'b0;
        penable[0] = 1'b0;
        clearModel();
        @(negedge clk);
        checkIdle(0, "reset mid-transfer");
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 8'h03, 8'h00, -1, 8'h00, 1'b0);
        applyStimulus(2, 1'b0, 8'h63, 8'h00, -1, 8'h00, 1'b0);

        // Random traffic against the array model.
        for (int n = 0; n < 80; n++) begin
            inst = int'($urandom_range(0, N - 1));
            wr   = 1'($urandom_range(0, 1));
            r    = int'($urandom_range(0, 9));
            if (r < 2) begin
                addr = 8'($urandom);
            end else if (r < 5) begin
                addr = 8'(depthOf(inst) - 4 + int'($urandom_range(0, 7)));
            end else begin
                addr = 8'($urandom_range(0, 15));
            end
            data = 8'($urandom);
            drop = -1;
            if (waitOf(inst) > 0 && $urandom_range(0, 7) == 0) begin
                drop = int'($urandom_range(0, waitOf(inst) - 1));
            end
            e = (int'(addr) >= depthOf(inst));
            applyStimulus(inst, wr, addr, data, drop,
                          e ? 8'h00 : model_mem[inst][addr], e);
            if ($urandom_range(0, 3) == 0) begin
                idleCycle(inst);
            end
        end
        idleCycle(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
